// File: rtl/hex_display_scanner.sv
// Scanned 8-digit common-anode hex display driver with change highlighting.
// Define HEXDISP_LZB_EN to blank leading-zero digits.
`timescale 1ns/1ps
module hex_display_scanner #(
    parameter int SCAN_DIV    = 50000,
    parameter int CHANGE_HOLD = 200
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] hexValue,
    input  logic        valueValid,
    input  logic        freeze,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [7:0]  digitEn,
    output logic        frameTick,
    output logic [31:0] shown
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);
    localparam logic [15:0] HOLD = 16'(CHANGE_HOLD);

    logic [31:0]   r_shown;
    logic [7:0]    r_mask;
    logic [15:0]   r_hold;
    logic [PW-1:0] r_presc;
    logic [2:0]    r_idx;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic [7:0]    r_en;
    logic          r_ft;

    logic       w_cap;
    logic       w_wrap;
    logic [7:0] w_diff;
    logic [3:0] w_nib;
    logic [6:0] w_seg;
    logic       w_blank;

    assign w_cap  = valueValid && !freeze;
    assign w_wrap = (r_presc == LAST);
    assign w_nib  = r_shown[{r_idx, 2'b00} +: 4];

    always_comb begin
        w_diff = '0;
        for (int i = 0; i < 8; i++)
            w_diff[i] = (hexValue[4*i +: 4] != r_shown[4*i +: 4]);
    end

    always_comb begin
        w_seg = 7'h7F;
        case (w_nib)
            4'h0: w_seg = 7'b1000000;
            4'h1: w_seg = 7'b1111001;
            4'h2: w_seg = 7'b0100100;
            4'h3: w_seg = 7'b0110000;
            4'h4: w_seg = 7'b0011001;
            4'h5: w_seg = 7'b0010010;
            4'h6: w_seg = 7'b0000010;
            4'h7: w_seg = 7'b1111000;
            4'h8: w_seg = 7'b0000000;
            4'h9: w_seg = 7'b0010000;
            4'hA: w_seg = 7'b0001000;
            4'hB: w_seg = 7'b0000011;
            4'hC: w_seg = 7'b1000110;
            4'hD: w_seg = 7'b0100001;
            4'hE: w_seg = 7'b0000110;
            default: w_seg = 7'b0001110;
        endcase
    end

`ifdef HEXDISP_LZB_EN
    logic [2:0] w_msd;

    always_comb begin
        w_msd = 3'd0;
        for (int i = 1; i < 8; i++)
            if (r_shown[4*i +: 4] != 4'h0)
                w_msd = 3'(i);
    end

    assign w_blank = (r_idx > w_msd);
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_shown <= '0;
            r_mask  <= '0;
            r_hold  <= '0;
            r_presc <= '0;
            r_idx   <= '0;
            r_seg   <= 7'h7F;
            r_dp    <= 1'b1;
            r_en    <= 8'hFF;
            r_ft    <= 1'b0;
        end else begin
            r_ft <= w_wrap && (r_idx == 3'd7);
            if (w_wrap) begin
                r_presc <= '0;
                r_idx   <= r_idx + 3'd1;
            end else begin
                r_presc <= r_presc + PW'(1);
            end

            if (w_cap)
                r_shown <= hexValue;

            // A changing capture reloads the hold even on a frame tick.
            if (w_cap && (w_diff != 8'h00)) begin
                r_mask <= w_diff;
                r_hold <= HOLD;
            end else if (r_ft && (r_hold != 16'd0)) begin
                r_hold <= r_hold - 16'd1;
                if (r_hold == 16'd1)
                    r_mask <= '0;
            end

            r_en  <= (r_presc == '0 || w_blank) ? 8'hFF : ~(8'h01 << r_idx);
            r_seg <= w_seg;
            r_dp  <= ~r_mask[r_idx] | w_blank;
        end
    end

    assign seg       = r_seg;
    assign dp        = r_dp;
    assign digitEn   = r_en;
    assign frameTick = r_ft;
    assign shown     = r_shown;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner, SCAN_DIV=4, CHANGE_HOLD=3.
`timescale 1ns/1ps
module tb_hex_display_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] hexValue;
    logic        valueValid;
    logic        freeze;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  digitEn;
    logic        frameTick;
    logic [31:0] shown;

    hex_display_scanner #(.SCAN_DIV(4), .CHANGE_HOLD(3)) dut (
        .clock(clk), .reset(reset), .hexValue(hexValue),
        .valueValid(valueValid), .freeze(freeze), .seg(seg), .dp(dp),
        .digitEn(digitEn), .frameTick(frameTick), .shown(shown)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] val;
        logic        vv;
        logic        frz;
        logic [31:0] exp_shown;
    } cap_t;

    int passed = 0;
    int total = 0;
    int cyc = 0;
    int rel = 0;
    logic [7:0] slot_en [8];
    cap_t caps [2];

    localparam logic [55:0] SEG_ZERO = {8{7'h40}};
    localparam logic [55:0] SEG_1TO8 =
        {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
    localparam logic [55:0] SEG_A5 = {{6{7'h40}}, 7'h08, 7'h12};

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h required=%h k=%0d",
                      nm, act, exp, cyc - rel);
    endtask

    function automatic int kidx(int k);
        return ((k - 1) / 4) % 8;
    endfunction

    function automatic bit kgap(int k);
        return ((k - 1) % 4) == 0;
    endfunction

    task automatic scan_chk(int kend, int msd, logic [55:0] segv, bit dp1);
        int k, i;
        bit g;
        logic [7:0] e;
        logic [55:0] sv;
        while (cyc - rel < kend) begin
            step();
            k = cyc - rel;
            i = kidx(k);
            g = kgap(k);
            e = g ? 8'hFF : slot_en[i];
`ifdef HEXDISP_LZB_EN
            if (i > msd) e = 8'hFF;
            if (i > msd) chk("lzb_dp", {31'd0, dp}, 32'd1);
`endif
            chk("digitEn", {24'd0, digitEn}, {24'd0, e});
            chk("frameTick", {31'd0, frameTick}, {31'd0, (k % 32) == 0});
            sv = segv >> (7 * i);
            if (e != 8'hFF) chk("seg", {25'd0, seg}, {25'd0, sv[6:0]});
            if (dp1) chk("dp_idle", {31'd0, dp}, 32'd1);
        end
        if (msd < 0) $display("unreachable msd");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog k=%0d", cyc - rel);
        $fatal(1);
    end

    initial begin
        int k;
        logic [55:0] sv;
        slot_en = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        caps[0] = '{32'h12345679, 1'b1, 1'b1, 32'h12345678};
        caps[1] = '{32'h12345679, 1'b1, 1'b0, 32'h12345679};

        reset = 1'b1; hexValue = '0; valueValid = 1'b0; freeze = 1'b0;
        repeat (3) step();
        chk("rst_en", {24'd0, digitEn}, 32'hFF);
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        chk("rst_dp", {31'd0, dp}, 32'd1);
        chk("rst_shown", shown, 32'h0);
        chk("rst_ft", {31'd0, frameTick}, 32'd0);

        reset = 1'b0;
        rel = cyc;
        scan_chk(64, 0, SEG_ZERO, 1'b1);

        hexValue = 32'h12345678; valueValid = 1'b1;
        step();
        valueValid = 1'b0;
        chk("cap_shown", shown, 32'h12345678);
        while (cyc - rel < 170) begin
            step();
            k = cyc - rel;
            chk("hold_dp", {31'd0, dp}, {31'd0, k > 161});
            sv = SEG_1TO8 >> (7 * kidx(k));
            if (k >= 97 && k <= 128 && !kgap(k))
                chk("seg_1to8", {25'd0, seg}, {25'd0, sv[6:0]});
        end

        for (int n = 0; n < 2; n++) begin
            hexValue = caps[n].val;
            valueValid = caps[n].vv;
            freeze = caps[n].frz;
            step();
            chk("frz_shown", shown, caps[n].exp_shown);
        end
        valueValid = 1'b0; freeze = 1'b0;
        while (cyc - rel < 229) begin
            step();
            k = cyc - rel;
            chk("d0_dp", {31'd0, dp}, {31'd0, kidx(k) != 0});
            if (kidx(k) == 0 && !kgap(k))
                chk("seg_9", {25'd0, seg}, 32'h10);
        end

        valueValid = 1'b1;
        step();
        valueValid = 1'b0;
        chk("same_shown", shown, 32'h12345679);
        while (cyc - rel < 290) begin
            step();
            k = cyc - rel;
            chk("same_dp", {31'd0, dp},
                {31'd0, !(kidx(k) == 0 && k <= 257)});
        end

        hexValue = 32'h000000A5; valueValid = 1'b1;
        step();
        valueValid = 1'b0;
        chk("a5_shown", shown, 32'h000000A5);
        step();
        scan_chk(324, 1, SEG_A5, 1'b0);

        hexValue = 32'h0; valueValid = 1'b1;
        step();
        valueValid = 1'b0;
        chk("z_shown", shown, 32'h0);
        step();
        scan_chk(360, 0, SEG_ZERO, 1'b0);

        hexValue = 32'h12345678; valueValid = 1'b1;
        step();
        valueValid = 1'b0;
        while (cyc - rel < 374) step();
        chk("pre_rst_en", {24'd0, digitEn}, 32'hDF);
        reset = 1'b1; valueValid = 1'b1; hexValue = 32'hFFFFFFFF;
        step();
        chk("mrst_en", {24'd0, digitEn}, 32'hFF);
        chk("mrst_seg", {25'd0, seg}, 32'h7F);
        chk("mrst_dp", {31'd0, dp}, 32'd1);
        chk("mrst_ft", {31'd0, frameTick}, 32'd0);
        chk("mrst_shown", shown, 32'h0);
        reset = 1'b0; valueValid = 1'b0;
        rel = cyc;
        scan_chk(40, 0, SEG_ZERO, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hex_display_scanner.md
# hex_display_scanner

Scanned seven-segment driver that sits directly downstream of the processor's debug display multiplexer and consumes its 32-bit hex display word. It captures the word on a strobe, time-multiplexes its eight nibbles onto one common-anode segment bus, and lights the decimal point of any digit whose value changed at the last capture for a programmable number of refresh frames. This lets the user see which part of a register (PC, IR, RA–RY) just moved while single-stepping.

## Interface
- SCAN_DIV, 50000: clock cycles per digit slot; minimum 2.
- CHANGE_HOLD, 200: refresh frames a changed digit keeps its decimal point lit; minimum 1, maximum 65535.

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- hexValue  in  32  display word from the debug mux
- valueValid  in  1  capture strobe, sampled every cycle
- freeze  in  1  when high, valueValid is ignored
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- digitEn  out  8  one-hot active-low anode enables; bit i drives nibble hexValue[4i+3:4i]
- frameTick  out  1  one-cycle pulse at the end of each 8-slot frame
- shown  out  32  currently captured word

## Operation
- Capture:
  - When valueValid && !freeze, `shown <= hexValue` at the next edge.
  - In the same edge, changeMask[i] is set to (new nibble i != old nibble i).
  - If the diff is nonzero, the hold counter loads CHANGE_HOLD and changeMask is replaced by the diff.
  - If the diff is zero (identical value), changeMask and the hold counter are unchanged.
- Hold counter:
  - Decrements on each frameTick while nonzero.
  - changeMask clears in the cycle the counter transitions 1→0.
  - A capture and a frameTick in the same cycle: the capture reload wins.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 and wraps.
  - On wrap, the digit index idx increments modulo 8 (7→0).
- Output register, updated every cycle:
  - digitEn = ~(1<<idx), except 8'hFF when prescaler==0 (one-cycle anti-ghosting gap per slot).
  - seg = hex decode of nibble idx of shown. Sample encodings: 0=1000000, 1=1111001, 5=0010010, 8=0000000, A=0001000, F=0001110.
  - dp = ~changeMask[idx].
- frameTick is 1 in the cycle after prescaler==SCAN_DIV-1 with idx==7 (registered).
- Reset values: shown=0, changeMask=0, hold counter=0, prescaler=0, idx=0, seg=7'h7F, dp=1, digitEn=8'hFF, frameTick=0.
- A reset asserted mid-frame or mid-hold restores all of the above at the next edge. A capture coincident with reset is discarded.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- Capture latency: shown updates 1 cycle after the valueValid edge.
- seg/dp reflect the new value 2 cycles after capture if that digit is active; otherwise from its next slot.
- Slot length is SCAN_DIV cycles, of which SCAN_DIV-1 cycles have the digit lit. Frame length is 8·SCAN_DIV cycles.
- frameTick period is exactly 8·SCAN_DIV cycles after the first frame following reset.
- The first lit cycle after reset release is cycle 2: digit 0 shows '0'.

## Configuration
- HEXDISP_LZB_EN defined: leading-zero blanking.
  - During the slot of any digit i above the most significant nonzero nibble of shown, digitEn stays 8'hFF and dp=1.
  - Digit 0 is always lit.
  - The scan timing and frameTick are unchanged.
- Not defined: all eight digits are lit in every frame.

## Test plan
- Reset for 3 cycles with SCAN_DIV=4 → digitEn=FF, seg=7F, dp=1, shown=0, frameTick=0. After release, from cycle 2 digitEn=FE and seg=1000000.
- SCAN_DIV=4, idle → digitEn sequence per slot is FF,x,x,x with x = FE,FD,FB,F7,EF,DF,BF,7F. frameTick pulses every 32 cycles.
- Capture 32'h12345678 with CHANGE_HOLD=3 → shown=12345678 next cycle. Digit 0 seg=0000000, digit 7 seg=1111001. dp=0 on all eight digits for 3 frames, then dp=1.
- freeze=1 with valueValid and 32'h12345679 → shown unchanged. Repeat with freeze=0 → only digit 0 shows dp=0. Recapturing the same value does not reload the hold counter.
- With HEXDISP_LZB_EN defined, capture 32'h000000A5 → digits 2–7 stay dark, digit 1 seg=0001000, digit 0 seg=0010010. Capture 0 → only digit 0 is lit, showing '0'. Without the macro, all eight digits are lit.
- Assert reset mid-hold and mid-slot (idx=5) → next edge shows all reset values, changeMask=0, and scanning restarts at digit 0.
